// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 defaults) and the coordinate/colour
// widths used across the display path.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 6;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter with
// combinational active-area and active-low sync decodes of the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               active,
  output logic               sync_n
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

  // wrap marks the advance that takes the counter from its last value to 0,
  // so the next axis can chain its own advance directly off it.
  assign wrap   = advance && (count == LAST);
  assign active = int'(count) < ACTIVE;
  assign sync_n = !((int'(count) >= ACTIVE + FP) && (int'(count) < ACTIVE + FP + SYNC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_pixel_sequencer.sv
// VGA timing generator and overlay/background pixel arbiter; RGB, Blank and
// syncs are registered one pixel period behind PIX_X/PIX_Y.
module vga_pixel_sequencer
  import vga_timing_pkg::*;
#(
  parameter int                 CLK_DIV  = 4,
  parameter int                 H_ACTIVE = H_ACTIVE_DEF,
  parameter int                 H_FP     = H_FP_DEF,
  parameter int                 H_SYNC   = H_SYNC_DEF,
  parameter int                 H_BP     = H_BP_DEF,
  parameter int                 V_ACTIVE = V_ACTIVE_DEF,
  parameter int                 V_FP     = V_FP_DEF,
  parameter int                 V_SYNC   = V_SYNC_DEF,
  parameter int                 V_BP     = V_BP_DEF,
  parameter logic [COLOR_W-1:0] KEY_RGB  = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ENABLE,
  output logic [COORD_W-1:0] PIX_X,
  output logic [COORD_W-1:0] PIX_Y,
  input  logic [COLOR_W-1:0] OVL_RGB,
  input  logic               OVL_VALID,
  input  logic [COLOR_W-1:0] BG_RGB,
  output logic [COLOR_W-1:0] RGB,
  output logic               Blank,
  output logic               HS,
  output logic               VS,
  output logic               FRAME_START
);

  // A one-bit divider keeps CLK_DIV=1 legal; it then sits at 0 and tick is constant.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [COORD_W-1:0] h_count, v_count;
  logic               h_wrap, v_wrap;
  logic               h_active, v_active;
  logic               h_sync_n, v_sync_n;
  logic               show;
  logic [COLOR_W-1:0] pix_rgb;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) h_ctr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .advance (tick),
    .count   (h_count),
    .wrap    (h_wrap),
    .active  (h_active),
    .sync_n  (h_sync_n)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) v_ctr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .advance (h_wrap),
    .count   (v_count),
    .wrap    (v_wrap),
    .active  (v_active),
    .sync_n  (v_sync_n)
  );

  assign PIX_X = h_count;
  assign PIX_Y = v_count;

  // An overlay pixel equal to the key colour is transparent and lets the background through.
  assign show    = h_active && v_active && ENABLE;
  assign pix_rgb = (OVL_VALID && (OVL_RGB != KEY_RGB)) ? OVL_RGB : BG_RGB;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RGB         <= '0;
      Blank       <= 1'b1;
      HS          <= 1'b1;
      VS          <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= v_wrap;
      if (tick) begin
        Blank <= !show;
        RGB   <= show ? pix_rgb : '0;
        HS    <= h_sync_n;
        VS    <= v_sync_n;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_sequencer.sv
// Randomised bench for vga_pixel_sequencer on reduced 16x8 timing, run side by
// side at CLK_DIV=2 and CLK_DIV=1 against an arithmetic reference model.
module tb_vga_pixel_sequencer;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int HIST = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ovl_valid = 1'b0;
  logic [5:0] ovl_rgb = '0;
  logic [5:0] bg_rgb = '0;

  logic [9:0] pix_x_d2, pix_y_d2, pix_x_d1, pix_y_d1;
  logic [5:0] rgb_d2, rgb_d1;
  logic       blank_d2, hs_d2, vs_d2, fs_d2;
  logic       blank_d1, hs_d1, vs_d1, fs_d1;

  // Input values present just before edge n (edges counted from reset release).
  logic       en_hist    [HIST];
  logic       valid_hist [HIST];
  logic [5:0] ovl_hist   [HIST];
  logic [5:0] bg_hist    [HIST];

  int checks = 0;
  int passes = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  vga_pixel_sequencer #(
    .CLK_DIV (2),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .KEY_RGB (6'b000000)
  ) dut_d2 (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ENABLE     (enable),
    .PIX_X      (pix_x_d2),
    .PIX_Y      (pix_y_d2),
    .OVL_RGB    (ovl_rgb),
    .OVL_VALID  (ovl_valid),
    .BG_RGB     (bg_rgb),
    .RGB        (rgb_d2),
    .Blank      (blank_d2),
    .HS         (hs_d2),
    .VS         (vs_d2),
    .FRAME_START(fs_d2)
  );

  vga_pixel_sequencer #(
    .CLK_DIV (1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .KEY_RGB (6'b000000)
  ) dut_d1 (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ENABLE     (enable),
    .PIX_X      (pix_x_d1),
    .PIX_Y      (pix_y_d1),
    .OVL_RGB    (ovl_rgb),
    .OVL_VALID  (ovl_valid),
    .BG_RGB     (bg_rgb),
    .RGB        (rgb_d1),
    .Blank      (blank_d1),
    .HS         (hs_d1),
    .VS         (vs_d1),
    .FRAME_START(fs_d1)
  );

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, exp);
  endtask

  // Expected outputs from the pixel index alone: edge e shows pixel e/d on the
  // coordinates and the colour/sync of the previous pixel, sampled at its last edge.
  task automatic checkOutput(input int d, input int e, input string tag,
                             input logic [9:0] px, input logic [9:0] py,
                             input logic [5:0] rgb, input logic blank,
                             input logic hs, input logic vs, input logic fs);
    int p, q, qh, qv, t;
    logic       e_blank, e_hs, e_vs, e_fs;
    logic [5:0] e_rgb;
    p = e / d;
    e_fs = (e > 0) && (e % (d * HT * VT) == 0);
    if (p == 0) begin
      e_blank = 1'b1; e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
    end else begin
      q  = p - 1;
      qh = q % HT;
      qv = (q / HT) % VT;
      t  = d * p;
      e_blank = !((qh < HA) && (qv < VA) && en_hist[t]);
      e_hs    = !((qh >= HA + HF) && (qh < HA + HF + HSW));
      e_vs    = !((qv >= VA + VF) && (qv < VA + VF + VSW));
      if (e_blank) e_rgb = '0;
      else if (valid_hist[t] && ovl_hist[t] != 6'd0) e_rgb = ovl_hist[t];
      else e_rgb = bg_hist[t];
    end
    cmp({tag, " PIX_X"}, 32'(px), 32'(p % HT));
    cmp({tag, " PIX_Y"}, 32'(py), 32'((p / HT) % VT));
    cmp({tag, " RGB"}, 32'(rgb), 32'(e_rgb));
    cmp({tag, " Blank"}, 32'(blank), 32'(e_blank));
    cmp({tag, " HS"}, 32'(hs), 32'(e_hs));
    cmp({tag, " VS"}, 32'(vs), 32'(e_vs));
    cmp({tag, " FRAME_START"}, 32'(fs), 32'(e_fs));
  endtask

  task automatic checkBoth(input string tag);
    checkOutput(2, edge_n, {tag, " d2"}, pix_x_d2, pix_y_d2, rgb_d2, blank_d2, hs_d2, vs_d2, fs_d2);
    checkOutput(1, edge_n, {tag, " d1"}, pix_x_d1, pix_y_d1, rgb_d1, blank_d1, hs_d1, vs_d1, fs_d1);
  endtask

  // Keyed overlay pixels are drawn often so transparency is exercised;
  // ENABLE drops for a full CLK_DIV=2 frame (edges 257..514).
  task automatic applyStimulus(input int idx);
    enable    = !(idx >= 257 && idx <= 514);
    ovl_valid = 1'($urandom_range(0, 1));
    ovl_rgb   = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
    bg_rgb    = 6'($urandom);
    en_hist[idx]    = enable;
    valid_hist[idx] = ovl_valid;
    ovl_hist[idx]   = ovl_rgb;
    bg_hist[idx]    = bg_rgb;
  endtask

  task automatic runEdges(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(edge_n + 1);
      @(posedge clk);
      edge_n++;
      #1;
      checkBoth(tag);
    end
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    edge_n = 0;
    checkBoth("reset");

    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
    checkBoth("release");
    runEdges(75, "run1");

    // Mid-period reset with the CLK_DIV=2 unit at h=5, v=2.
    #2;
    rst_n = 1'b0;
    #1;
    edge_n = 0;
    checkBoth("async_reset");

    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
    checkBoth("release2");
    runEdges(780, "run2");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
